// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM pass arbiter.
package sdram_arb_pkg;

  localparam int DW_DEF = 16;
  localparam int STW    = 3;

  typedef enum logic [STW-1:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_ARB       = 3'd2,
    S_START     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_RELEASE   = 3'd6
  } state_e;

endpackage

// File: rtl/sdram_pass_arbiter_rr_pick.sv
// Combinational round-robin selector: searches upward from last_i+1 (mod N),
// first set request wins.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  int pos;

  // Scan from farthest to nearest so the nearest hit overwrites earlier ones.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    pos   = 0;
    for (int k = N; k >= 1; k--) begin
      pos = (int'(last_i) + k) % N;
      if (req_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/sdram_pass_arbiter.sv
// Grants whole SDRAM engine passes round-robin to N requesters, steers data
// and strobes to the owner, and flags an engine that never goes busy.
module sdram_pass_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N        = 2,
  parameter int DW       = DW_DEF,
  parameter int START_TO = 64,
  parameter int IDW      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          req_rnw,
  input  logic [N-1:0][DW-1:0]  req_wdat,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          req_ready,
  output logic [N-1:0]          req_done,
  output logic [DW-1:0]         rdat,
  output logic                  dram_start,
  output logic                  dram_rnw,
  output logic [DW-1:0]         dram_wdat,
  input  logic                  dram_done,
  input  logic                  dram_ready,
  input  logic [DW-1:0]         dram_rdat,
  output logic                  busy,
  output logic [IDW-1:0]        owner_id,
  output logic                  timeout_err
);

  localparam int CW = $clog2(START_TO + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [IDW-1:0] owner_q, owner_d, last_q, last_d;
  logic           rnw_q, rnw_d, busy_q, busy_d, to_q, to_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   pick_oh;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    owner_d = owner_q;
    last_d  = last_q;
    rnw_d   = rnw_q;
    busy_d  = busy_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT_INIT: if (dram_done) state_d = S_IDLE;
      S_IDLE:      if (|req) state_d = S_ARB;
      S_ARB: begin
        // A request that vanished since IDLE just sends us back to wait.
        if (pick_any) begin
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          rnw_d   = |(req_rnw & pick_oh);
          busy_d  = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!dram_done) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_TO - 1)) begin
          to_d    = 1'b1;
          done_d  = gnt_q;
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (dram_done) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_INIT;
      gnt_q   <= '0;
      done_q  <= '0;
      owner_q <= '0;
      last_q  <= IDW'(N - 1);
      rnw_q   <= 1'b1;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rnw_q   <= rnw_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    dram_wdat = req_wdat[0];
    if (busy_q) begin
      for (int i = 0; i < N; i++) begin
        if (owner_q == IDW'(i)) dram_wdat = req_wdat[i];
      end
    end
  end

  assign gnt         = gnt_q;
  assign req_ready   = {N{dram_ready}} & gnt_q;
  assign req_done    = done_q;
  assign rdat        = dram_rdat;
  assign dram_start  = (state_q == S_START);
  assign dram_rnw    = rnw_q;
  assign busy        = busy_q;
  assign owner_id    = owner_q;
  assign timeout_err = to_q;

endmodule

// File: doc/sdram_pass_arbiter.md
Name: sdram_pass_arbiter

Overview:
Shares the single SDRAM pass engine (start/rnw/done/ready handshake, one full-array sweep per start) between N requesters, e.g. the random-pattern tester and a scrub/refresh-check client. It waits for controller init, grants whole passes round-robin, pulses start, and steers write data and the ready strobe to the owner. It returns a done pulse to the owner and flags a stuck controller with a timeout.

Parameters:
N, 2, number of requesters (2..8)
DW, 16, data width
START_TO, 64, max cycles from dram_start to dram_done falling before timeout
IDW, 3, width of owner_id (>= clog2(N))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N  per-requester pass request, level, held until its req_done
req_rnw  in  N  per-requester direction, 1=read pass, 0=write pass; sampled at grant
req_wdat  in  N*DW  per-requester write data, slice i = requester i
gnt  out  N  one-hot current owner, 0 when idle
req_ready  out  N  dram_ready routed to owner only
req_done  out  N  one-cycle pulse to owner at pass end
rdat  out  DW  dram_rdat broadcast, valid with owner's req_ready
dram_start  out  1  one-cycle start pulse to SDRAM engine
dram_rnw  out  1  latched direction of current pass
dram_wdat  out  DW  owner's req_wdat slice, combinational mux
dram_done  in  1  engine idle level (high after init and between passes)
dram_ready  in  1  per-word strobe from engine
dram_rdat  in  DW  read data from engine
busy  out  1  a pass is in flight
owner_id  out  IDW  binary index of owner, valid while busy
timeout_err  out  1  sticky, set on start timeout

Behaviour:
- Reset values: gnt=0, req_ready=0, req_done=0, dram_start=0, dram_rnw=1, busy=0, owner_id=0, timeout_err=0, last_owner=N-1, state=WAIT_INIT.
- States: WAIT_INIT -> IDLE when dram_done=1 (first done after engine init).
- IDLE: if any req bit set -> ARB next cycle; else stay.
- ARB: round-robin from last_owner+1 (mod N) upward; first set bit wins; latch owner_id, gnt, dram_rnw=req_rnw[winner]; busy=1; -> START.
- START: dram_start=1 for exactly one cycle; clear timeout counter; -> WAIT_BUSY.
- WAIT_BUSY: wait for dram_done=0; counter increments each cycle; counter reaching START_TO -> set timeout_err, pulse req_done to owner, -> RELEASE.
- WAIT_DONE: wait dram_done=1 -> pulse req_done[owner] one cycle, -> RELEASE.
- RELEASE: gnt=0, busy=0, last_owner=owner_id; -> IDLE. Requester drops req on the req_done cycle; a req still high in IDLE is a new pass.
- Latency: req rising in IDLE -> dram_start high 2 cycles later (ARB, START).
- req_ready[i] = dram_ready & gnt[i], combinational; rdat = dram_rdat always.
- dram_wdat = req_wdat slice owner_id while busy, else slice 0.
- req of owner dropped mid-pass: ignored, pass completes, done still pulsed.
- req_rnw changes mid-pass: ignored (latched).
- dram_ready outside WAIT_DONE: not routed (gnt gates it); no error.
- Simultaneous requests: exactly one grant; a non-owner never starved beyond N-1 passes.
- rst_n low mid-pass: all outputs to reset values immediately; state WAIT_INIT; timeout_err cleared.
- timeout_err cleared only by reset.

Decomposition:
- Package sdram_arb_pkg: state enum (WAIT_INIT, IDLE, ARB, START, WAIT_BUSY, WAIT_DONE, RELEASE), DW default, state width constant.
- Sub-module rr_pick: combinational round-robin selector (req vector, last index -> one-hot + binary index, any flag).

Test Plan:
- Reset, hold dram_done=0 50 cycles, assert req=01 -> no dram_start; raise dram_done -> dram_start pulse 2 cycles after IDLE reached, gnt=01, owner_id=0.
- req=11 held continuously, engine model 100-cycle passes -> grants alternate 0,1,0,1 over 4 passes; each req_done one cycle, gnt=0 one cycle in RELEASE.
- Owner 1 write pass, req_wdat slice1=16'hA5A5, slice0=16'h1234 -> dram_wdat=A5A5, dram_rnw=0; req_ready[0] stays 0 for all 256 dram_ready strobes.
- Engine never drops dram_done after start, START_TO=64 -> timeout_err=1 at cycle 64, req_done pulsed, next request still served.
- rst_n low during WAIT_DONE -> gnt=0, busy=0, timeout_err=0 same cycle; after release waits for dram_done before granting.
